// File: rtl/performance_ch_stat_collector.sv
// performance_ch_stat_collector
// Services the per-channel counters' ready / copy-complete handshake.
// A round-robin arbiter picks one ready channel at a time, its latency sum
// and request count are latched, a restoring divider produces the truncated
// average, and the result is written to per-channel output registers while
// copy-complete is pulsed back to that channel.
//
// Handshake: i_ready[k] is a level from counter k. A channel is eligible only
// when it is ready and armed. Arming is lost on grant and regained once ready
// is seen low outside of that channel's own service. This keeps the stale
// ready, which lingers briefly after o_cp_cmplt[k], from being granted twice.
// o_cp_cmplt[k] is a single-cycle pulse, one per grant.
module performance_ch_stat_collector #(
  parameter int CH      = 4,
  parameter int DATA_WD = 32,
  parameter int CNT_WD  = 12
) (
  input  logic                  i_bus_clk,
  input  logic                  i_bus_rst_n,
  input  logic [CH-1:0]         i_ready,
  input  logic [CH*DATA_WD-1:0] i_sum,
  input  logic [CH*CNT_WD-1:0]  i_req_cnt,
  output logic [CH-1:0]         o_cp_cmplt,
  output logic [CH*DATA_WD-1:0] o_avg,
  output logic [CH*CNT_WD-1:0]  o_sample_cnt,
  output logic [CH-1:0]         o_avg_valid,
  output logic [CH-1:0]         o_div_zero,
  input  logic [CH-1:0]         i_avg_rd,
  output logic                  o_busy,
  output logic [2:0]            o_dbg_state
);

  localparam int PTR_W = (CH > 1) ? $clog2(CH) : 1;
  localparam int IT_W  = $clog2(DATA_WD + 1);

  // DONE commits the result, CMPLT is the cycle in which copy-complete is
  // visible before the arbiter is allowed to grant again.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_DIV   = 3'd2,
    S_DONE  = 3'd3,
    S_CMPLT = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic [PTR_W-1:0]           gnt_q, gnt_d;
  logic [CH-1:0]              armed_q, armed_d;
  logic [DATA_WD-1:0]         dvd_q, dvd_d;
  logic [CNT_WD-1:0]          dvs_q, dvs_d;
  logic [DATA_WD-1:0]         quo_q, quo_d;
  logic [CNT_WD:0]            rem_q, rem_d;
  logic [IT_W-1:0]            it_q, it_d;
  logic [CH-1:0][DATA_WD-1:0] avg_q, avg_d;
  logic [CH-1:0][CNT_WD-1:0]  scnt_q, scnt_d;
  logic [CH-1:0]              valid_q, valid_d;
  logic [CH-1:0]              dz_q, dz_d;
  logic [CH-1:0]              cp_q, cp_d;
  logic                       busy_q, busy_d;

  logic [CH-1:0][DATA_WD-1:0] sum_arr;
  logic [CH-1:0][CNT_WD-1:0]  cnt_arr;
  logic [CH-1:0]              elig;
  logic                       found;
  logic [PTR_W-1:0]           pick;
  logic [CNT_WD+1:0]          rem_sh;
  logic [CNT_WD+1:0]          rem_full;
  logic                       q_bit;

  assign sum_arr = i_sum;
  assign cnt_arr = i_req_cnt;
  assign elig    = i_ready & armed_q;

  // base + off, wrapped into the channel range
  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= CH) s = s - CH;
    return PTR_W'(s);
  endfunction

  // Round-robin search: first eligible channel at or above the pointer
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < CH; i++) begin
      if (!found && elig[rr_idx(ptr_q, i)]) begin
        found = 1'b1;
        pick  = rr_idx(ptr_q, i);
      end
    end
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_sh   = {rem_q, dvd_q[DATA_WD-1]};
    q_bit    = (rem_sh >= {2'b00, dvs_q});
    rem_full = q_bit ? (rem_sh - {2'b00, dvs_q}) : rem_sh;
  end

  // Arming: drop on grant, re-arm when ready is seen low outside own service
  always_comb begin
    armed_d = armed_q;
    for (int k = 0; k < CH; k++) begin
      if (!i_ready[k] && !((state_q != S_IDLE) && (gnt_q == PTR_W'(k)))) armed_d[k] = 1'b1;
    end
    if ((state_q == S_IDLE) && found) armed_d[pick] = 1'b0;
  end

  // Sequencer: grant, latch operands, divide, commit result and pulse copy-complete
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    it_d    = it_q;
    avg_d   = avg_q;
    scnt_d  = scnt_q;
    valid_d = valid_q & ~i_avg_rd;
    dz_d    = dz_q & ~i_avg_rd;
    cp_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = pick;
          ptr_d   = rr_idx(pick, 1);
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        dvd_d   = sum_arr[gnt_q];
        dvs_d   = cnt_arr[gnt_q];
        quo_d   = '0;
        rem_d   = '0;
        it_d    = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        if (it_q == IT_W'(DATA_WD)) begin
          state_d = S_DONE;
        end else begin
          dvd_d = {dvd_q[DATA_WD-2:0], 1'b0};
          quo_d = {quo_q[DATA_WD-2:0], q_bit};
          rem_d = (CNT_WD+1)'(rem_full);
          it_d  = it_q + 1'b1;
        end
      end
      S_DONE: begin
        // a same-cycle read pulse loses to this write
        avg_d[gnt_q]   = (dvs_q == '0) ? '1 : quo_q;
        scnt_d[gnt_q]  = dvs_q;
        valid_d[gnt_q] = 1'b1;
        dz_d[gnt_q]    = (dvs_q == '0);
        cp_d[gnt_q]    = 1'b1;
        state_d        = S_CMPLT;
      end
      S_CMPLT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_bus_clk or negedge i_bus_rst_n) begin
    if (!i_bus_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      armed_q <= '1;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      it_q    <= '0;
      avg_q   <= '0;
      scnt_q  <= '0;
      valid_q <= '0;
      dz_q    <= '0;
      cp_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      armed_q <= armed_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      it_q    <= it_d;
      avg_q   <= avg_d;
      scnt_q  <= scnt_d;
      valid_q <= valid_d;
      dz_q    <= dz_d;
      cp_q    <= cp_d;
      busy_q  <= busy_d;
    end
  end

  assign o_cp_cmplt   = cp_q;
  assign o_avg        = avg_q;
  assign o_sample_cnt = scnt_q;
  assign o_avg_valid  = valid_q;
  assign o_div_zero   = dz_q;
  assign o_busy       = busy_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_performance_ch_stat_collector.sv
// Bench for performance_ch_stat_collector: drives the counter side of the
// handshake, predicts each channel's result from sum/count arithmetic and
// checks it whenever copy-complete appears.
module tb_performance_ch_stat_collector;

  localparam int CH = 4;
  localparam int DW = 32;
  localparam int CW = 12;
  localparam int EW = 1 + CW + DW;

  logic             clk;
  logic             rst_n;
  logic [CH-1:0]    ready;
  logic [CH*DW-1:0] sum;
  logic [CH*CW-1:0] cnt;
  logic [CH-1:0]    avg_rd;
  logic [CH-1:0]    cp;
  logic [CH*DW-1:0] avg;
  logic [CH*CW-1:0] scnt;
  logic [CH-1:0]    valid;
  logic [CH-1:0]    dz;
  logic             busy;
  logic [2:0]       dbg_state;

  int tests = 0;
  int fails = 0;

  // expected {div_zero, sample_cnt, avg} per channel, in issue order
  logic [EW-1:0] exp_q[CH][$];
  int            got_order[$];

  performance_ch_stat_collector #(.CH(CH), .DATA_WD(DW), .CNT_WD(CW)) dut (
    .i_bus_clk    (clk),
    .i_bus_rst_n  (rst_n),
    .i_ready      (ready),
    .i_sum        (sum),
    .i_req_cnt    (cnt),
    .o_cp_cmplt   (cp),
    .o_avg        (avg),
    .o_sample_cnt (scnt),
    .o_avg_valid  (valid),
    .o_div_zero   (dz),
    .i_avg_rd     (avg_rd),
    .o_busy       (busy),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // reference: truncated unsigned average, all ones when the count is zero
  function automatic logic [EW-1:0] model(input logic [DW-1:0] s, input logic [CW-1:0] c);
    logic [DW-1:0] a;
    if (c == 0) a = {DW{1'b1}};
    else        a = s / {{(DW-CW){1'b0}}, c};
    return {(c == 0), c, a};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start(input int k, input logic [DW-1:0] s, input logic [CW-1:0] c);
    sum[k*DW +: DW] = s;
    cnt[k*CW +: CW] = c;
    exp_q[k].push_back(model(s, c));
    ready[k] = 1'b1;
  endtask

  task automatic wait_cp(input int k);
    bit got = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (cp[k]) begin
        got = 1;
        break;
      end
    end
    check($sformatf("cp_seen_ch%0d", k), 64'(got), 64'd1);
  endtask

  // counter clears and restarts: ready lingers 0..1 cycles, then stays low a while
  task automatic drop(input int k);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    ready[k] = 1'b0;
    repeat ($urandom_range(2, 4)) @(negedge clk);
  endtask

  task automatic chan_txn(input int k, input logic [DW-1:0] s, input logic [CW-1:0] c);
    start(k, s, c);
    wait_cp(k);
    drop(k);
  endtask

  task automatic wait_busy(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && (cp != '0)) begin
      check("cp_onehot", 64'($countones(cp)), 64'd1);
      for (int k = 0; k < CH; k++) begin
        if (cp[k]) begin
          got_order.push_back(k);
          if (exp_q[k].size() == 0) begin
            check($sformatf("unexpected_cp_ch%0d", k), 64'd1, 64'd0);
          end else begin
            logic [EW-1:0] e;
            e = exp_q[k].pop_front();
            check($sformatf("result_ch%0d", k),
                  64'({dz[k], scnt[k*CW +: CW], avg[k*DW +: DW]}), 64'(e));
            check($sformatf("valid_ch%0d", k), 64'(valid[k]), 64'd1);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int n;
    int busy_cnt;

    rst_n  = 1'b0;
    ready  = '0;
    sum    = '0;
    cnt    = '0;
    avg_rd = '0;
    repeat (3) @(negedge clk);
    check("rst_cp",    64'(cp),    64'd0);
    check("rst_avg",   64'(avg[63:0]) | 64'(avg[127:64]), 64'd0);
    check("rst_scnt",  64'(scnt),  64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_dz",    64'(dz),    64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // arbitration from a fresh pointer: all four ready at once
    got_order.delete();
    for (int k = 0; k < CH; k++) start(k, $urandom, 12'($urandom_range(1, 4095)));
    for (int i = 0; i < 400 && got_order.size() < CH; i++) @(negedge clk);
    check("arb_count", 64'(got_order.size()), 64'(CH));
    for (int k = 0; k < CH && k < got_order.size(); k++)
      check($sformatf("arb_order%0d", k), 64'(got_order[k]), 64'(k));
    // ready held high after copy-complete must not be granted again
    repeat (3) @(negedge clk);
    busy_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("no_regrant_held_ready", 64'(busy_cnt), 64'd0);
    ready = '0;
    repeat (3) @(negedge clk);

    // single channel with latency measured from the grant edge
    start(1, 32'd25000, 12'd100);
    wait_busy(ok);
    check("grant_seen", 64'(ok), 64'd1);
    n = 0;
    while (!cp[1] && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("cp_latency", 64'(n), 64'd35);
    check("avg_ch1", 64'(avg[1*DW +: DW]), 64'd250);
    @(negedge clk);
    check("cp_one_cycle", 64'(cp), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    drop(1);

    // width, truncation and divide by zero
    chan_txn(0, 32'hFFFF_FFFF, 12'hFFF);
    chan_txn(3, 32'd7, 12'd2);
    chan_txn(0, 32'd5, 12'd0);
    check("dz_set",    64'(dz[0]),    64'd1);
    check("dz_valid",  64'(valid[0]), 64'd1);
    avg_rd[0] = 1'b1;
    @(negedge clk);
    avg_rd[0] = 1'b0;
    @(negedge clk);
    check("rd_clr_valid", 64'(valid[0]), 64'd0);
    check("rd_clr_dz",    64'(dz[0]),    64'd0);

    // read pulse on the commit cycle of channel 2: the write wins
    start(2, 32'd1000, 12'd9);
    wait_busy(ok);
    check("grant_seen2", 64'(ok), 64'd1);
    repeat (34) @(posedge clk);
    #1 avg_rd[2] = 1'b1;
    @(posedge clk);
    #1 avg_rd[2] = 1'b0;
    repeat (3) @(negedge clk);
    check("collision_valid", 64'(valid[2]), 64'd1);
    drop(2);

    // randomized traffic on all channels concurrently
    for (int k = 0; k < CH; k++) begin
      automatic int kk = k;
      fork
        begin
          for (int t = 0; t < 5; t++) begin
            logic [CW-1:0] c;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            c = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
            chan_txn(kk, $urandom, c);
          end
        end
      join_none
    end
    wait fork;

    // reset in the middle of a division, then re-service the held ready
    start(1, 32'd99999, 12'd37);
    wait_busy(ok);
    check("grant_seen3", 64'(ok), 64'd1);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_cp",    64'(cp),    64'd0);
    check("mid_rst_avg",   64'(avg[63:0]) | 64'(avg[127:64]), 64'd0);
    check("mid_rst_scnt",  64'(scnt),  64'd0);
    check("mid_rst_valid", 64'(valid), 64'd0);
    check("mid_rst_dz",    64'(dz),    64'd0);
    check("mid_rst_busy",  64'(busy),  64'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_no_cp", 64'(cp), 64'd0);
    rst_n = 1'b1;
    wait_cp(1);
    drop(1);

    repeat (5) @(negedge clk);
    for (int k = 0; k < CH; k++)
      check($sformatf("exp_empty_ch%0d", k), 64'(exp_q[k].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
